// File: rtl/beep_pkg.sv
// beep_pkg: shared state enum, note codes, period table and ROM entry layout for the buzzer scheduler
package beep_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_NOTE, ST_GAP, ST_DONE} state_e;
  localparam int NOTE_W = 4;
  localparam int DUR_W = 2;
  localparam int ENTRY_W = 1 + DUR_W + NOTE_W;
  localparam int ADDR_W = 7;
  localparam int PERIOD_W = 18;
  localparam logic [25:0] TICK_UNIT_DEF = 26'd12_499_999;
  localparam logic [21:0] GAP_CYC_DEF = 22'd2_500_000;
  localparam logic [NOTE_W-1:0] N_REST = 4'd0;
  localparam logic [NOTE_W-1:0] N_DO = 4'd1;
  localparam logic [NOTE_W-1:0] N_RE = 4'd2;
  localparam logic [NOTE_W-1:0] N_MI = 4'd3;
  localparam logic [NOTE_W-1:0] N_FA = 4'd4;
  localparam logic [NOTE_W-1:0] N_SO = 4'd5;
  localparam logic [NOTE_W-1:0] N_LA = 4'd6;
  localparam logic [NOTE_W-1:0] N_XI = 4'd7;
  localparam logic [NOTE_W-1:0] N_DOO = 4'd8;

  // Codes above DOO fall back to DO so a corrupt entry still sounds a sane pitch.
  function automatic logic [PERIOD_W-1:0] period_of(input logic [NOTE_W-1:0] n);
    case (n)
      N_REST: return 18'd0;
      N_RE: return 18'd170068;
      N_MI: return 18'd151515;
      N_FA: return 18'd143266;
      N_SO: return 18'd127551;
      N_LA: return 18'd113636;
      N_XI: return 18'd101214;
      N_DOO: return 18'd95556;
      default: return 18'd190840;
    endcase
  endfunction

  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] r;
    r = ptr;
    for (int i = 3; i >= 0; i--) if (req[ptr + 2'(i)]) r = ptr + 2'(i);
    return r;
  endfunction
endpackage

// File: rtl/beep_song_scheduler_if.sv
// beep_song_scheduler_if: request/abort inputs and tone-generator outputs of the buzzer scheduler
interface beep_song_scheduler_if;
  import beep_pkg::*;
  logic [3:0] req;
  logic stop;
  logic [3:0] grant;
  logic [PERIOD_W-1:0] tone_period;
  logic tone_en;
  logic busy;
  logic done;
  modport master (output req, stop, input grant, tone_period, tone_en, busy, done);
  modport slave (input req, stop, output grant, tone_period, tone_en, busy, done);
endinterface

// File: rtl/beep_song_rom.sv
// beep_song_rom: 4 songs x 32 entries of {last, dur, note}; unlisted entries read as zero
module beep_song_rom
  import beep_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] data_o
);
  always_comb begin
    data_o = '0;
    case (addr_i)
      7'd0: data_o = {1'b0, 2'd0, N_SO};
      7'd1: data_o = {1'b0, 2'd0, N_DOO};
      7'd2: data_o = {1'b0, 2'd0, N_SO};
      7'd3: data_o = {1'b1, 2'd0, N_DOO};
      7'd32: data_o = {1'b0, 2'd1, N_SO};
      7'd33: data_o = {1'b0, 2'd0, N_SO};
      7'd34: data_o = {1'b0, 2'd0, N_LA};
      7'd35: data_o = {1'b0, 2'd2, N_RE};
      7'd36: data_o = {1'b0, 2'd1, N_DO};
      7'd37: data_o = {1'b0, 2'd0, N_DO};
      7'd38: data_o = {1'b0, 2'd0, N_LA};
      7'd39: data_o = {1'b0, 2'd2, N_RE};
      7'd40: data_o = {1'b0, 2'd0, N_SO};
      7'd41: data_o = {1'b0, 2'd0, N_SO};
      7'd42: data_o = {1'b0, 2'd0, N_LA};
      7'd43: data_o = {1'b0, 2'd0, N_DOO};
      7'd44: data_o = {1'b0, 2'd0, N_LA};
      7'd45: data_o = {1'b0, 2'd0, N_SO};
      7'd46: data_o = {1'b0, 2'd0, N_DO};
      7'd47: data_o = {1'b0, 2'd0, N_DO};
      7'd48: data_o = {1'b0, 2'd0, N_LA};
      7'd49: data_o = {1'b1, 2'd3, N_RE};
      7'd64: data_o = {1'b0, 2'd0, N_DO};
      7'd65: data_o = {1'b0, 2'd0, N_MI};
      7'd66: data_o = {1'b0, 2'd1, N_REST};
      7'd67: data_o = {1'b0, 2'd0, N_SO};
      7'd68: data_o = {1'b1, 2'd1, N_DOO};
      7'd96: data_o = {1'b1, 2'd0, 4'd12};
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/beep_song_scheduler.sv
// beep_song_scheduler: round-robin owner of the buzzer, walks the granted song's notes with gaps.
// Define BEEP_SCHED_PREEMPT_EN to let req[0] (alarm) take over at the next note boundary.
module beep_song_scheduler
  import beep_pkg::*;
#(
  parameter logic [25:0] TICK_UNIT = TICK_UNIT_DEF,
  parameter logic [21:0] GAP_CYC = GAP_CYC_DEF,
  parameter int N_REQ = 4
) (
  input logic clk,
  input logic rst_n,
  beep_song_scheduler_if.slave bus_if
);
  state_e state_q, state_d, bnd_state;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [1:0] rr_q, rr_d, pick, dur_q, dur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic en_q, en_d, last_q, last_d;
  logic [25:0] unit_q, unit_d;
  logic [21:0] gap_q, gap_d;
  logic [ENTRY_W-1:0] entry;
  logic note_end, gap_end, bnd, own_req, abort, preempt;

  beep_song_rom u_rom (.addr_i(addr_q), .data_o(entry));

  assign pick = rr_pick(bus_if.req, rr_q);
  assign note_end = unit_q == '0 && dur_q == '0;
  assign gap_end = gap_q == '0;
  assign own_req = |(bus_if.req & grant_q);
  assign abort = bus_if.stop && state_q != ST_IDLE;
  assign bnd = (state_q == ST_GAP && gap_end) || (state_q == ST_NOTE && note_end && GAP_CYC == '0);
`ifdef BEEP_SCHED_PREEMPT_EN
  assign preempt = bus_if.req[0] && !grant_q[0];
`else
  assign preempt = 1'b0;
`endif
  assign bnd_state = preempt ? ST_LOAD : last_q ? ST_DONE : own_req ? ST_LOAD : ST_IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = |bus_if.req ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_NOTE;
      ST_NOTE: state_d = !note_end ? ST_NOTE : GAP_CYC != '0 ? ST_GAP : bnd_state;
      ST_GAP: state_d = gap_end ? bnd_state : ST_GAP;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    bus_if.busy = state_q != ST_IDLE;
    bus_if.done = state_q == ST_DONE;
  end

  assign bus_if.grant = grant_q;
  assign bus_if.tone_period = period_q;
  assign bus_if.tone_en = en_q;

  always_comb begin
    grant_d = grant_q;
    rr_d = rr_q;
    addr_d = addr_q;
    period_d = period_q;
    en_d = en_q;
    last_d = last_q;
    unit_d = unit_q;
    dur_d = dur_q;
    gap_d = gap_q;
    case (state_q)
      ST_IDLE: if (|bus_if.req) begin
        grant_d = N_REQ'(1) << pick;
        addr_d = {pick, 5'd0};
        rr_d = pick + 2'd1;
      end
      ST_LOAD: begin
        period_d = period_of(entry[NOTE_W-1:0]);
        en_d = entry[NOTE_W-1:0] != N_REST;
        last_d = entry[ENTRY_W-1] | &addr_q[4:0];
        unit_d = TICK_UNIT;
        dur_d = entry[NOTE_W+:DUR_W];
      end
      ST_NOTE: if (unit_q != '0) unit_d = unit_q - 26'd1;
      else if (dur_q != '0) begin
        dur_d = dur_q - 2'd1;
        unit_d = TICK_UNIT;
      end else begin
        en_d = 1'b0;
        gap_d = GAP_CYC - 22'd1;
      end
      ST_GAP: if (!gap_end) gap_d = gap_q - 22'd1;
      default: ;
    endcase
    // Same-cycle boundary decision for both the gap end and a gapless note end.
    if (bnd) begin
      if (preempt) begin
        grant_d = N_REQ'(1);
        addr_d = '0;
        rr_d = 2'd1;
      end else if (last_q || !own_req) grant_d = '0;
      else addr_d = {addr_q[6:5], addr_q[4:0] + 5'd1};
    end
    if (abort) begin
      grant_d = '0;
      en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_q <= '0;
      rr_q <= '0;
      addr_q <= '0;
      period_q <= '0;
      en_q <= 1'b0;
      last_q <= 1'b0;
      unit_q <= '0;
      dur_q <= '0;
      gap_q <= '0;
    end else begin
      grant_q <= grant_d;
      rr_q <= rr_d;
      addr_q <= addr_d;
      period_q <= period_d;
      en_q <= en_d;
      last_q <= last_d;
      unit_q <= unit_d;
      dur_q <= dur_d;
      gap_q <= gap_d;
    end
endmodule

// File: doc/beep_song_scheduler.md
# beep_song_scheduler

Schedules the shared buzzer tone generator among up to four song requesters, such as a play key, an alarm or a power-on jingle. It grants one requester at a time by round-robin and walks that requester's note list from a small song ROM. For each note it drives a divider period and an enable to the downstream square-wave tone generator, inserting a silent articulation gap between notes. It sits between the key/event logic and the tone generator on the Zynq-7020 board.

## Interface
- `TICK_UNIT`, default 26'd12_499_999: duration unit minus one, in clk cycles (250 ms at 50 MHz).
- `GAP_CYC`, default 22'd2_500_000: silent gap after each note, in cycles (50 ms). 0 = no gap.
- `N_REQ`, default 4: number of requesters. Fixed at 4 in this revision.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 4: level requests. Bit i asks for song i.
- `stop` in 1: single-cycle abort of the current song.
- `grant` out 4: one-hot owner of the tone generator; 0 when idle.
- `tone_period` out 18: divider period handed to the tone generator.
- `tone_en` out 1: tone generator enable; 1 only while a non-rest note sounds.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a song completes normally.

## Operation
- States are IDLE, LOAD, NOTE, GAP and DONE.
- Reset values: all outputs 0, state IDLE, RR pointer 0, ROM address 0.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit starting from the RR pointer, wrapping 3→0.
  - Register `grant` and set address = song*32.
  - Set the RR pointer to song+1 mod 4.
  - Go to LOAD.
- **LOAD:**
  - Read the ROM entry {last, dur[1:0], note[3:0]}.
  - Register `tone_period` = period table[note] and `tone_en` = (note != 0).
  - Load the duration counters. Go to NOTE.
- **NOTE:**
  - Lasts exactly (dur+1)*(TICK_UNIT+1) cycles.
  - Then `tone_en` goes to 0 and the state goes to GAP, or skips GAP when GAP_CYC = 0.
- **GAP:**
  - Lasts GAP_CYC cycles. `tone_period` holds its value.
  - At the end: if `last`, go to DONE. If the granted `req` bit has dropped, go to IDLE with no `done` (abort). Otherwise address+1 and go to LOAD.
- **DONE:** `done` = 1 for one cycle, `grant` is cleared, then go to IDLE.
- **`stop`:** in any non-IDLE state, next cycle goes to IDLE with `grant`, `tone_en` and `busy` at 0 and no `done`. A `stop` in IDLE is ignored.
- **Address wrap:** the address increments within the 32-entry song window. Entry 31 is always treated as last, even if its `last` bit is 0.
- **Note codes:**
  - 0 = rest: `tone_en` = 0, but the duration still elapses.
  - 1–8 = DO, RE, MI, FA, SO, LA, XI, DOO with periods 190840, 170068, 151515, 143266, 127551, 113636, 101214, 95556.
  - 9–15 map to DO.
- **Arithmetic:** the unit counter is 26-bit and the unit count is 2-bit; no overflow is possible.
- **Simultaneous events:** `stop` takes precedence over note/gap end and over `done`. New requests are sampled only in IDLE.

## Timing
- `req` seen high at edge k (IDLE) → `grant`/`busy` at edge k+1 (LOAD) → `tone_en`/`tone_period` valid at edge k+2.
- Per-note period is 1 + (dur+1)*(TICK_UNIT+1) + GAP_CYC cycles, where the leading 1 is the LOAD cycle.
- `done` is asserted the cycle after GAP ends for the last entry. `busy` falls the cycle after `done`.
- A re-request in the cycle after `done` is re-arbitrated with the advanced RR pointer.
- Reset mid-song: outputs go to 0 immediately (asynchronous) and the pointer returns to 0.

## Configuration
- `BEEP_SCHED_PREEMPT_EN` defined:
  - `req[0]` (alarm) preempts any other granted song at the end of its current NOTE/GAP boundary.
  - No `done` is issued for the preempted song.
  - `grant` switches directly to bit 0, and the next cycle is LOAD at address 0.
- Undefined: there is no preemption. A song runs to completion, `stop`, or its own request dropping.

## Structure
- Package `beep_pkg` holds:
  - the state enum;
  - the note-code constants and the 18-bit period table;
  - the ROM entry field widths;
  - default TICK/GAP constants shared with the tone generator.
- Sub-module `beep_song_rom`: combinational 128×7 lookup (4 songs × 32 entries).
  - Song 0 is the alarm: SO/DOO alternating, 4 entries.
  - Song 1 is The East Is Red, 18 notes.
  - Songs 2–3 are a short jingle and a one-entry click.

## Test plan
Bench parameters: TICK_UNIT=9, GAP_CYC=3.
- **Basic play:** `req`=4'b0010 held → `grant`=0010 two cycles later, first `tone_period`=127551. After all 18 notes, `done` pulses once and `busy` drops the next cycle.
- **Round-robin:** `req`=4'b0011 held through two songs → grant order 0001, 0010, 0001. There is exactly 1 IDLE cycle between songs.
- **Abort by `stop`:** `stop` pulses during the third note of song 1 → next cycle `tone_en`=0, `grant`=0, `busy`=0, and no `done`.
- **Request drop:** deassert `req[1]` mid-note → the note and its 3-cycle gap complete, then IDLE with no `done`.
- **Rest and timing:** on a ROM entry with note=0, dur=1 → `tone_en` stays 0 for exactly 20 cycles, followed by a 3-cycle gap.
- **Preemption (`BEEP_SCHED_PREEMPT_EN`):** song 2 playing, `req[0]` rises → at the next note boundary `grant`=0001 and `tone_period`=127551. With the macro undefined, song 2 plays to `done` first.
